afifo_rd_ctrl: RTL and testbench

//  Read-side controller for the aFIFO: consumes the aFIFO read port (empty/pop/data_out) in the rdclk domain
//  and re-presents words on a valid/ready stream, hiding the 1-cycle pop-to-data latency with a 2-entry skid buffer.

---
 rtl/tb_fifo_pkg.sv | 20 ++
 rtl/afifo_rd_ctrl_if.sv | 29 ++
 rtl/afifo_skid_buf.sv | 47 ++++
 rtl/afifo_rd_ctrl.sv | 80 ++++++++
 tb/tb_afifo_rd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tb_fifo_pkg.sv
// Shared types for the aFIFO slice: data word, read-controller states and skid sizing.
package tb_fifo_pkg;

    typedef logic [7:0] data_t;

    typedef enum logic [1:0] {
        RC_RUN,
        RC_DRAIN,
        RC_DONE
    } rdctl_state_e;

    localparam int SKID_DEPTH = 2;

    // True when a new pop cannot overflow the skid: words already owed (buffered + in flight)
    // minus the one leaving this cycle must stay below the depth.
    function automatic logic skid_has_room(input logic [1:0] occ, input logic inflight, input logic deq);
        return ({1'b0, occ} + {2'b00, inflight}) < ({1'b0, 2'(SKID_DEPTH)} + {2'b00, deq});
    endfunction

endpackage

// File: rtl/afifo_rd_ctrl_if.sv
// aFIFO read port plus the downstream valid/ready stream, as seen by the read controller.
interface afifo_rd_ctrl_if;

    logic                fifo_empty;
    tb_fifo_pkg::data_t  fifo_data;
    logic                fifo_pop;
    tb_fifo_pkg::data_t  m_data;
    logic                m_valid;
    logic                m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_pop,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_pop,
        input  m_data,
        input  m_valid
    );

endinterface

// File: rtl/afifo_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs; the second entry only fills
// while the output word is stalled.
module afifo_skid_buf
    import tb_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  data_t      push_data,
    input  logic       out_ready,
    output data_t      out_data,
    output logic       out_valid,
    output logic [1:0] occ
);

    data_t hold_data_p1;
    logic  hold_valid_p1;
    logic  deq;

    assign deq = out_valid & out_ready;
    assign occ = {1'b0, out_valid} + {1'b0, hold_valid_p1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            hold_valid_p1 <= 1'b0;
        end else if (!out_valid || deq) begin
            if (hold_valid_p1) begin
                out_data      <= hold_data_p1;
                out_valid     <= 1'b1;
                hold_valid_p1 <= push;
            end else begin
                out_valid <= push;
                if (push) out_data <= push_data;
            end
        end else if (push) begin
            hold_valid_p1 <= 1'b1;
        end
    end

    // Second entry captures whenever it will be (re)filled; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (push && ((out_valid && !out_ready) || hold_valid_p1)) hold_data_p1 <= push_data;
    end

endmodule

// File: rtl/afifo_rd_ctrl.sv
// aFIFO read-side controller: stream pops into a skid buffer, plus a drain mode that discards
// everything left in the aFIFO.
module afifo_rd_ctrl
    import tb_fifo_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  rdclk,
    input  logic                  rd_rst,
    input  logic                  en,
    input  logic                  drain_req,
    afifo_rd_ctrl_if.master       bus,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    rdctl_state_e state, state_nxt;
    logic         inflight_strm_p1;
    logic         inflight_drop_p1;
    logic         pop_strm;
    logic         pop_drop;
    logic [1:0]   occ;
    logic         deq;

    assign deq = bus.m_valid & bus.m_ready;

    always_comb begin
        state_nxt = state;
        pop_strm  = 1'b0;
        pop_drop  = 1'b0;
        unique case (state)
            RC_RUN: begin
                pop_strm = en & ~bus.fifo_empty & skid_has_room(occ, inflight_strm_p1, deq);
                if (drain_req) state_nxt = RC_DRAIN;
            end
            RC_DRAIN: begin
                pop_drop = ~bus.fifo_empty;
                if (bus.fifo_empty && !inflight_drop_p1) state_nxt = RC_DONE;
            end
            RC_DONE:  state_nxt = RC_RUN;
            default:  state_nxt = RC_RUN;
        endcase
    end

    // Held low during reset so the aFIFO never loses a word while the controller is cleared.
    assign bus.fifo_pop = rd_rst & (pop_strm | pop_drop);
    assign drain_busy   = (state == RC_DRAIN);
    assign drain_done   = (state == RC_DONE);

    always_ff @(posedge rdclk or negedge rd_rst) begin
        if (!rd_rst) begin
            state            <= RC_RUN;
            inflight_strm_p1 <= 1'b0;
            inflight_drop_p1 <= 1'b0;
            pop_count        <= '0;
            drop_count       <= '0;
        end else begin
            state            <= state_nxt;
            inflight_strm_p1 <= pop_strm;
            inflight_drop_p1 <= pop_drop;
            if (pop_strm)         pop_count  <= pop_count + CNT_WIDTH'(1);
            if (inflight_drop_p1) drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    // Stage p1: returned stream words land in the skid; discarded words are simply not pushed.
    afifo_skid_buf u_skid (
        .clk       (rdclk),
        .rst_n     (rd_rst),
        .push      (inflight_strm_p1),
        .push_data (bus.fifo_data),
        .out_ready (bus.m_ready),
        .out_data  (bus.m_data),
        .out_valid (bus.m_valid),
        .occ       (occ)
    );

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Bench for afifo_rd_ctrl: array-backed aFIFO model, word-order scoreboard and an
// outstanding-word model of the pop rule.
module tb_afifo_rd_ctrl;
    import tb_fifo_pkg::*;

    localparam int CW = 16;

    logic          rdclk = 1'b0;
    logic          rd_rst = 1'b1;
    logic          en = 1'b0;
    logic          drain_req = 1'b0;
    logic          force_empty = 1'b0;
    logic          drain_busy, drain_done;
    logic [CW-1:0] pop_count, drop_count;

    data_t fifo_mem [0:1023];
    int    wr_ptr = 0;
    int    rd_ptr = 0;
    data_t exp_q [$];

    int tests_run = 0;
    int tests_failed = 0;

    afifo_rd_ctrl_if bus ();

    afifo_rd_ctrl #(.CNT_WIDTH(CW)) dut (
        .rdclk      (rdclk),
        .rd_rst     (rd_rst),
        .en         (en),
        .drain_req  (drain_req),
        .bus        (bus.master),
        .drain_busy (drain_busy),
        .drain_done (drain_done),
        .pop_count  (pop_count),
        .drop_count (drop_count)
    );

    always #5 rdclk = ~rdclk;

    assign bus.fifo_empty = (rd_ptr == wr_ptr) || force_empty;

    // aFIFO read port: data_out is valid the cycle after a pop.
    always @(posedge rdclk) begin
        if (bus.fifo_pop && !bus.fifo_empty) begin
            bus.fifo_data <= fifo_mem[rd_ptr[9:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic push_word(input data_t d);
        fifo_mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rd_rst = 1'b0;
        en = 1'b0;
        drain_req = 1'b0;
        force_empty = 1'b0;
        bus.m_ready = 1'b0;
        exp_q.delete();
        @(negedge rdclk);
        @(negedge rdclk);
        rd_rst = 1'b1;
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        #1 rd_rst = 1'b0;
        en = 1'b1;
        bus.m_ready = 1'b1;
        exp_q.delete();
        for (int i = 1; i <= 8; i++) push_word(data_t'(i));
        @(negedge rdclk);
        @(negedge rdclk);
        #1;
        tests_run++; if (bus.fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL reset_pop: got %b want 0", bus.fifo_pop); end
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
        tests_run++; if (bus.m_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h want 0", bus.m_data); end
        tests_run++; if (pop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_pop_count: got %0d want 0", pop_count); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        tests_run++; if (drain_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", drain_busy); end
        tests_run++; if (drain_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", drain_done); end
        @(negedge rdclk);
    endtask

    // Uses the eight words loaded while reset was held.
    task automatic test_stream();
        int first_pop = -1;
        int k = 0;
        data_t w;
        rd_rst = 1'b1;
        for (int cyc = 0; cyc < 30 && k < 8; cyc++) begin
            #1;
            if (bus.fifo_pop && first_pop < 0) first_pop = cyc;
            if (bus.m_valid && bus.m_ready) begin
                w = exp_q.pop_front();
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL stream_data: got %0h want %0h", bus.m_data, w); end
                tests_run++; if (cyc != first_pop + 2 + k) begin tests_failed++; $display("FAIL stream_timing: got cycle %0d want %0d", cyc, first_pop + 2 + k); end
                k++;
            end
            @(negedge rdclk);
        end
        #1;
        tests_run++; if (k != 8) begin tests_failed++; $display("FAIL stream_count: got %0d want 8", k); end
        tests_run++; if (pop_count !== 16'd8) begin tests_failed++; $display("FAIL stream_pop_count: got %0d want 8", pop_count); end
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_idle_valid: got %b want 0", bus.m_valid); end
        @(negedge rdclk);
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int k = 0;
        int first = -1;
        data_t w;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 6; i++) push_word(data_t'(i));
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1; if (bus.fifo_pop) pops++;
            @(negedge rdclk);
        end
        #1;
        tests_run++; if (pops != 2) begin tests_failed++; $display("FAIL bp_pops: got %0d want 2", pops); end
        tests_run++; if (bus.fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL bp_pop_stalled: got %b want 0", bus.fifo_pop); end
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h01) begin tests_failed++; $display("FAIL bp_hold: got v=%b d=%0h want v=1 d=01", bus.m_valid, bus.m_data); end
        @(negedge rdclk);
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
            #1;
            if (bus.m_valid && bus.m_ready) begin
                w = exp_q.pop_front();
                if (first < 0) first = cyc;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL bp_data: got %0h want %0h", bus.m_data, w); end
                tests_run++; if (cyc != first + k) begin tests_failed++; $display("FAIL bp_gap: got cycle %0d want %0d", cyc, first + k); end
                k++;
            end
            @(negedge rdclk);
        end
        tests_run++; if (k != 6) begin tests_failed++; $display("FAIL bp_count: got %0d want 6", k); end
        tests_run++; if (pop_count !== 16'd6) begin tests_failed++; $display("FAIL bp_pop_count: got %0d want 6", pop_count); end
    endtask

    task automatic test_drain();
        int drain_pops = 0;
        int dones = 0;
        int busy_bad = 0;
        int k = 0;
        bit seen = 1'b0;
        data_t w;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 7; i++) push_word(data_t'(i));
        repeat (5) @(negedge rdclk);
        #1;
        tests_run++; if (pop_count !== 16'd2) begin tests_failed++; $display("FAIL drain_prefill: got %0d want 2", pop_count); end
        drain_req = 1'b1;
        @(negedge rdclk);
        drain_req = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus.fifo_pop) drain_pops++;
            if (drain_done) begin dones++; seen = 1'b1; end
            else if (drain_busy !== !seen) busy_bad++;
            @(negedge rdclk);
        end
        tests_run++; if (drain_pops != 5) begin tests_failed++; $display("FAIL drain_pops: got %0d want 5", drain_pops); end
        tests_run++; if (drop_count !== 16'd5) begin tests_failed++; $display("FAIL drain_drop_count: got %0d want 5", drop_count); end
        tests_run++; if (dones != 1) begin tests_failed++; $display("FAIL drain_done_pulses: got %0d want 1", dones); end
        tests_run++; if (busy_bad != 0) begin tests_failed++; $display("FAIL drain_busy: got %0d bad cycles want 0", busy_bad); end
        tests_run++; if (pop_count !== 16'd2) begin tests_failed++; $display("FAIL drain_pop_count: got %0d want 2", pop_count); end
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (bus.m_valid && bus.m_ready) begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL drain_buffered: got %0h want %0h", bus.m_data, w); end
                k++;
            end
            @(negedge rdclk);
        end
        tests_run++; if (k != 2) begin tests_failed++; $display("FAIL drain_delivered: got %0d want 2", k); end
    endtask

    task automatic test_edge_cases();
        int kk;
        int pops = 0;
        int late_pops = 0;
        int got = 0;
        data_t w;
        // Drain with nothing to discard.
        do_reset();
        drain_req = 1'b1;
        @(negedge rdclk);
        drain_req = 1'b0;
        #1;
        tests_run++; if (drain_busy !== 1'b1 || drain_done !== 1'b0) begin tests_failed++; $display("FAIL empty_drain_c1: got busy=%b done=%b want 1 0", drain_busy, drain_done); end
        @(negedge rdclk);
        #1;
        tests_run++; if (drain_done !== 1'b1 || drain_busy !== 1'b0) begin tests_failed++; $display("FAIL empty_drain_c2: got done=%b busy=%b want 1 0", drain_done, drain_busy); end
        @(negedge rdclk);
        #1;
        tests_run++; if (drain_done !== 1'b0) begin tests_failed++; $display("FAIL empty_drain_c3: got done=%b want 0", drain_done); end
        tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL empty_drain_drops: got %0d want 0", drop_count); end
        // en dropped mid-stream.
        do_reset();
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_word(data_t'($urandom));
        kk = $urandom_range(2, 5);
        for (int cyc = 0; cyc < kk; cyc++) begin
            #1;
            if (bus.fifo_pop) pops++;
            if (bus.m_valid) begin
                w = exp_q.pop_front(); got++;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL en_off_data: got %0h want %0h", bus.m_data, w); end
            end
            @(negedge rdclk);
        end
        en = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (bus.fifo_pop) late_pops++;
            if (bus.m_valid) begin
                w = exp_q.pop_front(); got++;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL en_off_data: got %0h want %0h", bus.m_data, w); end
            end
            @(negedge rdclk);
        end
        tests_run++; if (pops != kk) begin tests_failed++; $display("FAIL en_on_pops: got %0d want %0d", pops, kk); end
        tests_run++; if (late_pops != 0) begin tests_failed++; $display("FAIL en_off_pops: got %0d want 0", late_pops); end
        tests_run++; if (got != kk) begin tests_failed++; $display("FAIL en_off_delivered: got %0d want %0d", got, kk); end
        en = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 10; cyc++) begin
            #1;
            if (bus.m_valid) begin
                w = exp_q.pop_front(); got++;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL en_resume_data: got %0h want %0h", bus.m_data, w); end
            end
            @(negedge rdclk);
        end
        tests_run++; if (got != 10) begin tests_failed++; $display("FAIL en_resume_count: got %0d want 10", got); end
    endtask

    task automatic test_reset_mid_drain();
        int remaining;
        int got = 0;
        data_t w;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 8; i++) push_word(data_t'($urandom));
        repeat (4) @(negedge rdclk);
        drain_req = 1'b1;
        @(negedge rdclk);
        drain_req = 1'b0;
        @(negedge rdclk);
        #1;
        tests_run++; if (drain_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_drain_busy: got %b want 1", drain_busy); end
        #2 rd_rst = 1'b0;
        #1;
        tests_run++; if (bus.fifo_pop !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin tests_failed++; $display("FAIL mid_drain_rst_stream: got pop=%b v=%b d=%0h want 0 0 0", bus.fifo_pop, bus.m_valid, bus.m_data); end
        tests_run++; if (pop_count !== 16'd0 || drop_count !== 16'd0) begin tests_failed++; $display("FAIL mid_drain_rst_counts: got %0d %0d want 0 0", pop_count, drop_count); end
        tests_run++; if (drain_busy !== 1'b0 || drain_done !== 1'b0) begin tests_failed++; $display("FAIL mid_drain_rst_flags: got busy=%b done=%b want 0 0", drain_busy, drain_done); end
        @(negedge rdclk);
        exp_q.delete();
        for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(fifo_mem[i[9:0]]);
        remaining = exp_q.size();
        rd_rst = 1'b1;
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < remaining; cyc++) begin
            #1;
            if (bus.m_valid) begin
                w = exp_q.pop_front(); got++;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL post_rst_data: got %0h want %0h", bus.m_data, w); end
            end
            @(negedge rdclk);
        end
        tests_run++; if (got != remaining) begin tests_failed++; $display("FAIL post_rst_count: got %0d want %0d", got, remaining); end
        tests_run++; if (pop_count !== CW'(remaining)) begin tests_failed++; $display("FAIL post_rst_pop_count: got %0d want %0d", pop_count, remaining); end
    endtask

    // Random en / m_ready / fifo_empty; pop rule re-derived from words owed to the stream.
    task automatic test_random();
        localparam int N = 60;
        int popped = 0;
        int delivered = 0;
        int owed;
        bit deq, exp_pop;
        data_t w;
        do_reset();
        for (int i = 0; i < N; i++) push_word(data_t'($urandom));
        for (int cyc = 0; cyc < 800 && delivered < N; cyc++) begin
            #1;
            deq = bus.m_valid && bus.m_ready;
            owed = popped - delivered - int'(deq);
            exp_pop = en && !bus.fifo_empty && (owed < SKID_DEPTH);
            tests_run++; if (bus.fifo_pop !== exp_pop) begin tests_failed++; $display("FAIL rnd_pop cyc %0d: got %b want %b", cyc, bus.fifo_pop, exp_pop); end
            if (deq) begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
                tests_run++; if (bus.m_data !== w) begin tests_failed++; $display("FAIL rnd_data cyc %0d: got %0h want %0h", cyc, bus.m_data, w); end
                delivered++;
            end
            if (bus.fifo_pop) popped++;
            @(negedge rdclk);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            en          = ($urandom_range(0, 7) != 0);
            force_empty = ($urandom_range(0, 5) == 0);
        end
        force_empty = 1'b0;
        tests_run++; if (delivered != N) begin tests_failed++; $display("FAIL rnd_delivered: got %0d want %0d", delivered, N); end
        tests_run++; if (pop_count !== CW'(N)) begin tests_failed++; $display("FAIL rnd_pop_count: got %0d want %0d", pop_count, N); end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_edge_cases();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
